// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// A transfer completes in the cycle mem_ready is sampled high while mem_req is high.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: checks alignment, lane-shifts store data, runs one memory
// handshake per accepted start and extracts/extends the loaded value.
// Unrecognised split options behave as lw. An unusual store mask is classified
// by its widest lane: bit 3 set means word, else bit 1 set means halfword.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            memory_write_enable,
    input  logic [2:0]            memory_split_option,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  misaligned,
    output logic                  bus_error,
    load_store_unit_if.master     mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]            cnt_q;
    logic                  mis_q;
    logic                  berr_q;

    // Request captured at start; held stable for the whole REQ phase.
    logic                  we_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [3:0]            be_p1;
    logic [31:0]           wdata_p1;
    logic [2:0]            opt_p1;
    logic [1:0]            off_p1;

    logic                  is_store;
    logic                  is_word;
    logic                  is_half;
    logic                  aligned;
    logic                  last_try;

    // Sign/zero extension of the addressed lane(s) of the read word.
    function automatic logic [31:0] extract_load(input logic [2:0]  opt,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic        [31:0] w;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        w = rdata >> {off, 3'b000};
        b = w[7:0];
        h = w[15:0];
        case (opt)
            3'b001:  r = h;
            3'b010:  r = {16'h0000, w[15:0]};
            3'b011:  r = b;
            3'b100:  r = {24'h000000, w[7:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Access classification and alignment of the incoming request.
    always_comb begin
        is_store = (memory_write_enable != 4'b0000);
        is_word  = 1'b0;
        is_half  = 1'b0;
        if (is_store) begin
            is_word = memory_write_enable[3];
            is_half = !memory_write_enable[3] && memory_write_enable[1];
        end else begin
            is_half = (memory_split_option == 3'b001) || (memory_split_option == 3'b010);
            is_word = !is_half && (memory_split_option != 3'b011)
                               && (memory_split_option != 3'b100);
        end
        aligned = !(is_word && (address[1:0] != 2'b00)) && !(is_half && address[0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus/status outputs; bus outputs are zero outside REQ.
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        misaligned    = 1'b0;
        bus_error     = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'h0;
        last_try      = (cnt_q == 8'(TIMEOUT - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = aligned ? REQ : DONE;
                end
            end
            REQ: begin
                busy          = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_p1;
                mem.mem_addr  = addr_p1;
                mem.mem_be    = be_p1;
                mem.mem_wdata = wdata_p1;
                if (mem.mem_ready || last_try) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                misaligned = mis_q;
                bus_error  = berr_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request lanes when an aligned access is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start && aligned) begin
            we_p1    <= is_store;
            addr_p1  <= {address[ADDR_WIDTH-1:2], 2'b00};
            be_p1    <= is_store ? (memory_write_enable << address[1:0]) : 4'b0000;
            wdata_p1 <= store_data << {address[1:0], 3'b000};
            opt_p1   <= memory_split_option;
            off_p1   <= address[1:0];
        end
    end

    // Timeout counter, completion flags and the held load result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            load_data <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (start) begin
                        mis_q  <= !aligned;
                        berr_q <= 1'b0;
                        if (!aligned) begin
                            load_data <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        load_data <= we_p1 ? 32'h0 : extract_load(opt_p1, off_p1, mem.mem_rdata);
                    end else if (last_try) begin
                        berr_q    <= 1'b1;
                        load_data <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    cnt_q <= 8'd0;
                end
            endcase
        end
    end

endmodule
